// File: rtl/ram_arbiter.sv
// Shares one single-port BRAM between a read-only fetch port and a read/write data port.
// Read data returns 1 cycle after accept; losers see ready=0 and hold; an optional zero-fill runs after reset.
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int STARVE_LIMIT   = 3,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CLEAR_DEPTH    = 32768
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  ram_en,
  output logic [1:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  ram_regce,
  output logic                  ram_rst
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST   = ADDR_WIDTH'(CLEAR_DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [SW-1:0]         starve_cnt, starve_cnt_nxt;
  logic                  starve;
  logic                  rsp_if, rsp_d;

  assign starve = (starve_cnt >= STARVE_MAX);

  // Outputs are also gated by reset so they drop the moment reset asserts.
  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    starve_cnt_nxt = starve_cnt;
    if_ready       = 1'b0;
    d_ready        = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 2'b00;
    ram_addr       = '0;
    ram_di         = d_wdata;
    if (!reset) begin
      case (state)
        S_CLEAR: begin
          ram_en      = 1'b1;
          ram_we      = 2'b11;
          ram_di      = '0;
          ram_addr    = clr_cnt;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          d_ready  = d_req & ~(if_req & starve);
          if_ready = if_req & ~d_ready;
          if (d_ready) begin
            ram_en   = 1'b1;
            ram_addr = d_addr;
            ram_we   = {2{d_we}};
          end else if (if_ready) begin
            ram_en   = 1'b1;
            ram_addr = if_addr;
          end
          if (if_req && !if_ready) begin
            if (!starve) starve_cnt_nxt = starve_cnt + 1'b1;
          end else begin
            starve_cnt_nxt = '0;
          end
        end
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST_STATE;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      rsp_if     <= 1'b0;
      rsp_d      <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      rsp_if     <= if_req & if_ready;
      rsp_d      <= d_req & d_ready;
    end
  end

  assign init_done = ~reset & (state == S_RUN);
  assign if_rvalid = rsp_if;
  assign d_rvalid  = rsp_d;
  assign if_rdata  = rsp_if ? ram_do : '0;
  assign d_rdata   = rsp_d  ? ram_do : '0;
  assign ram_regce = 1'b0;
  assign ram_rst   = 1'b0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural WRITE_FIRST BRAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done;
  logic        if_req = 1'b0;
  logic [14:0] if_addr = '0;
  logic        if_ready, if_rvalid;
  logic [7:0]  if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [14:0] d_addr = '0;
  logic [7:0]  d_wdata = '0;
  logic        d_ready, d_rvalid;
  logic [7:0]  d_rdata;
  logic        ram_en;
  logic [1:0]  ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic        ram_regce, ram_rst;

  logic [7:0]  mem [0:32767];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH(15), .DATA_WIDTH(8), .STARVE_LIMIT(3),
    .CLEAR_ON_RESET(1), .CLEAR_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do), .ram_regce(ram_regce), .ram_rst(ram_rst)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we[0]) begin
        mem[ram_addr] <= ram_di;
        ram_do        <= ram_di;
      end else begin
        ram_do <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input logic we, input logic [14:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp);
    next_cycle();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    chk("d_ready", d_ready, 1);
    chk("ram_we", ram_we, {2{we}});
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk("d_rvalid", d_rvalid, 1);
    chk("d_rdata", d_rdata, exp);
  endtask

  initial begin
    int n;
    int stale;
    logic exp_if, prev_if;

    for (int i = 0; i < 64; i++) mem[i] <= 8'hA5 ^ 8'(i);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ready", {if_ready, d_ready}, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("regce_rst", {ram_regce, ram_rst}, 0);

    // clear sequence
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      chk("clr_addr", ram_addr, c);
      chk("clr_we_en", {ram_en, ram_we}, 3'b111);
      chk("clr_di", ram_di, 0);
      chk("clr_init_done", init_done, 0);
    end
    next_cycle();
    chk("init_done_16", init_done, 1);

    for (int a = 0; a < 16; a++) d_access(1'b0, 15'(a), 8'h00, 8'h00);

    // data write then read
    d_access(1'b1, 15'h0100, 8'h5A, 8'h5A);
    d_access(1'b0, 15'h0100, 8'h00, 8'h5A);

    // fetch-only stream
    for (int i = 0; i < 8; i++) mem[i] <= 8'hC0 + 8'(i);
    for (int i = 0; i <= 8; i++) begin
      next_cycle();
      if_req = (i < 8);
      if_addr = 15'(i);
      @(negedge clk);
      if (i < 8) chk("if_ready_stream", if_ready, 1);
      if (i > 0) begin
        chk("if_rvalid_stream", if_rvalid, 1);
        chk("if_rdata_stream", if_rdata, 8'hC0 + 8'(i - 1));
      end
    end
    next_cycle();
    @(negedge clk);
    chk("if_rvalid_end", if_rvalid, 0);

    // contention: D,D,D,IF repeating
    for (int k = 0; k <= 12; k++) begin
      next_cycle();
      if_req = (k < 12); d_req = (k < 12);
      d_we = 1'b0; d_addr = 15'h0100; if_addr = 15'd3;
      @(negedge clk);
      if (k < 12) begin
        exp_if = ((k % 4) == 3);
        chk("arb_if_ready", if_ready, exp_if);
        chk("arb_d_ready", d_ready, !exp_if);
      end
      if (k > 0) begin
        prev_if = (((k - 1) % 4) == 3);
        chk("arb_if_rvalid", if_rvalid, prev_if);
        chk("arb_d_rvalid", d_rvalid, !prev_if);
        if (prev_if) chk("arb_if_rdata", if_rdata, 8'hC3);
        else chk("arb_d_rdata", d_rdata, 8'h5A);
      end
    end

    // reset in the middle of a clear
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
    end
    chk("mid_clr_addr", ram_addr, 7);
    #1 reset = 1'b1;
    #1;
    chk("mid_clr_en", ram_en, 0);
    chk("mid_clr_we", ram_we, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("restart_addr", ram_addr, 0);
    chk("restart_en", ram_en, 1);
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      next_cycle();
      n++;
    end
    chk("restart_done_cycles", n, 16);

    // reset in the cycle after a read accept
    d_req = 1'b1; d_we = 1'b0; d_addr = 15'h0100;
    @(negedge clk);
    chk("pre_rst_d_ready", d_ready, 1);
    next_cycle();
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    chk("drop_d_rvalid", d_rvalid, 0);
    chk("drop_d_rdata", d_rdata, 0);
    next_cycle();
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_rvalid || if_rvalid) stale++;
      next_cycle();
    end
    chk("no_stale_rsp", stale, 0);
    chk("post_init_done", init_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
